// File: rtl/shift_seq_ctrl.sv
// Iterative shifter for the EX stage: one shared shift stage applied once per
// cycle, stage k (by 2^k) gated by shamt[k], LSB first; stalls the pipe while busy.
module shift_seq_ctrl #(
    parameter int WIDTH      = 32,
    parameter int SHW        = 5,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_src,
    input  logic [SHW-1:0]   i_shamt,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_stall
);
    localparam int CW = (SHW > 1) ? $clog2(SHW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_nxt;
    logic [WIDTH-1:0] r_data, r_result;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_op;
    logic [SHW-1:0]   r_shamt;

    logic [WIDTH-1:0]   w_shifted, w_step;
    logic [2*WIDTH-1:0] w_rot;
    logic [SHW-1:0]     w_amt, w_upper;
    logic               w_accept, w_zero, w_last;

    // Shared stage: shift amount is the one-hot 2^k for the current step.
    always_comb begin
        w_amt        = '0;
        w_amt[r_cnt] = 1'b1;
        w_rot        = {r_data, r_data} >> w_amt;
        w_shifted    = r_data;
        case (r_op)
            2'b00:   w_shifted = r_data << w_amt;
            2'b01:   w_shifted = r_data >> w_amt;
            2'b11:   w_shifted = $signed(r_data) >>> w_amt;
            default: w_shifted = w_rot[WIDTH-1:0];
        endcase
        w_step  = r_shamt[r_cnt] ? w_shifted : r_data;
        w_upper = (r_shamt >> r_cnt) >> 1;
        w_last  = (r_cnt == CW'(SHW - 1)) | (EARLY_EXIT & (w_upper == '0));
    end

    assign w_zero   = EARLY_EXIT & (i_shamt == '0);
    assign w_accept = i_start & ~i_flush & (r_state != S_SHIFT);

    always_comb begin
        w_nxt = S_IDLE;
        case (r_state)
            S_SHIFT: begin
                if (i_flush)     w_nxt = S_IDLE;
                else if (w_last) w_nxt = S_DONE;
                else             w_nxt = S_SHIFT;
            end
            default: begin
                if (w_accept) w_nxt = w_zero ? S_DONE : S_SHIFT;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_data   <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_shamt  <= '0;
        end else begin
            r_state <= w_nxt;
            if (r_state != S_SHIFT) begin
                if (w_accept) begin
                    r_op    <= i_op;
                    r_shamt <= i_shamt;
                    r_cnt   <= '0;
                    r_data  <= i_src;
                    // Zero-amount fast path skips SHIFT, so publish src directly.
                    if (w_zero) r_result <= i_src;
                end
            end else if (!i_flush) begin
                r_data <= w_step;
                r_cnt  <= r_cnt + 1'b1;
                if (w_last) r_result <= w_step;
            end
        end
    end

    assign o_busy   = (r_state == S_SHIFT);
    assign o_done   = (r_state == S_DONE);
    assign o_result = r_result;
    assign o_stall  = (r_state == S_SHIFT) | (w_accept & ~w_zero);
endmodule
